pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; every flop is rising-edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port stall, input, 1, pipeline hold from hazard logic.
REQ-005 SHALL have port redirect_valid, input, 1, a branch/jump target is presented this cycle.
REQ-006 SHALL have port redirect_target, input, 32, next-PC target computed by ID-stage next-PC logic.
REQ-007 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-008 SHALL have port imem_ack, input, 1, instruction memory accepts imem_addr this cycle.
REQ-009 SHALL have port imem_addr, output, 32, fetch address, equal to PC.
REQ-010 SHALL have port PC, output, 32, current fetch PC.
REQ-011 SHALL have port PC4, output, 32, PC+4, forwarded to next-PC logic and the IF/ID register.
REQ-012 SHALL have port if_valid, output, 1, one-cycle pulse: instruction at PC accepted, advance taken.
REQ-013 SHALL have port addr_err, output, 1, misaligned redirect flag (see REQ-030).

Function
REQ-014 SHALL define advance = imem_req & imem_ack & ~stall; PC changes only on advance.
REQ-015 SHALL drive imem_req = 1 in every cycle after reset deassertion, with imem_addr held stable until imem_ack.
REQ-016 SHALL compute PC4 = PC + 32'd4 combinationally, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 SHALL drive if_valid = advance, combinationally, same cycle.
REQ-018 SHALL implement a two-state FSM: RUN (no pending redirect) and PEND (target latched, not yet applied).
REQ-019 SHALL, in RUN with advance and redirect_valid, load PC <= redirect_target and stay in RUN.
REQ-020 SHALL, in RUN with advance and no redirect_valid, load PC <= PC4 and stay in RUN.
REQ-021 SHALL, in RUN with redirect_valid and no advance, latch pend_target <= redirect_target and go to PEND; PC unchanged.
REQ-022 SHALL, in PEND, ignore redirect_valid; the first latched target wins.
REQ-023 SHALL, in PEND on advance, load PC <= pend_target and return to RUN.
REQ-024 SHALL apply the redirect at the advance that fetches the instruction after the delay slot; the delay-slot instruction, which is in IF when the redirect is asserted, is always fetched at the current PC.
REQ-025 SHALL add zero latency: a redirect accepted with advance makes the target the PC in the next cycle.

Reset
REQ-026 SHALL, while reset_n = 0, force PC = RESET_PC, state = RUN, pend_target = 0, and imem_req = 0; if_valid and addr_err SHALL consequently be 0.
REQ-027 SHALL, on reset asserted mid-operation (including in PEND), discard any pending redirect with no residual effect after release.
REQ-028 SHALL assert imem_req in the first cycle after reset_n rises, with imem_addr = RESET_PC.

Configuration
REQ-029 SHALL gate misalignment checking with macro PC_MISALIGN_CHECK_EN.
REQ-030 SHALL, when PC_MISALIGN_CHECK_EN is defined, treat redirect_valid with redirect_target[1:0] != 0 as rejected:
- addr_err = 1 for that cycle;
- no latch, no state change;
- the sequential path (PC4) is taken on advance.
REQ-031 SHALL, when PC_MISALIGN_CHECK_EN is undefined, tie addr_err to 0 and use {redirect_target[31:2], 2'b00} as the target.

Verification
REQ-032 SHALL cover reset: reset_n low, then high, imem_ack = 1 -> PC sequence 0x3000, 0x3004, 0x3008, with if_valid = 1 each cycle.
REQ-033 SHALL cover redirect with advance: at PC = 0x3008, redirect_valid = 1, target = 0x3100, ack = 1 -> next PC = 0x3100, FSM stays RUN.
REQ-034 SHALL cover redirect under stall: at PC = 0x3008, redirect = 0x3200 with stall = 1 for 3 cycles, then a second redirect = 0x3300 -> PC holds at 0x3008, FSM in PEND, first advance gives PC = 0x3200.
REQ-035 SHALL cover memory wait: imem_ack = 0 for 4 cycles at PC = 0x3010 -> imem_addr stable at 0x3010, if_valid = 0; ack = 1 -> PC = 0x3014.
REQ-036 SHALL cover wrap-around: PC forced to 0xFFFF_FFFC via redirect, then advance -> PC = 0x0000_0000.
REQ-037 SHALL cover misalignment with PC_MISALIGN_CHECK_EN defined: target = 0x3102 at PC = 0x3008 with advance -> addr_err = 1 and next PC = 0x300C; reset_n pulsed while in PEND -> PC = 0x3000, FSM = RUN.

Source files
------------

// File: rtl/pc_fetch.sv
// IF-stage program counter with one-entry pending-redirect buffer.
// Ports: clk, reset_n, stall, redirect_valid/target in; imem_req/ack/addr,
// PC, PC4, if_valid, addr_err out. Optional: PC_MISALIGN_CHECK_EN.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic [31:0] imem_addr,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        if_valid,
    output logic        addr_err
);

    typedef enum logic {
        RUN,
        PEND
    } state_t;

    state_t      state;
    logic [31:0] pend_target;
    logic        req_q;
    logic        advance;
    logic        redir_ok;
    logic [31:0] redir_tgt;

    assign imem_req  = req_q;
    assign imem_addr = PC;
    assign PC4       = PC + 32'd4;
    assign advance   = req_q & imem_ack & ~stall;
    assign if_valid  = advance;

`ifdef PC_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |redirect_target[1:0];
    // A misaligned target is dropped; the fetch falls through to PC4.
    assign redir_ok   = redirect_valid & ~misaligned;
    assign redir_tgt  = redirect_target;
    assign addr_err   = req_q & redirect_valid & misaligned;
`else
    assign redir_ok   = redirect_valid;
    assign redir_tgt  = redirect_target & ~32'h0000_0003;
    assign addr_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PC          <= RESET_PC;
            state       <= RUN;
            pend_target <= 32'h0;
            req_q       <= 1'b0;
        end else begin
            req_q <= 1'b1;
            unique case (state)
                RUN: begin
                    if (advance) begin
                        PC <= redir_ok ? redir_tgt : PC4;
                    end else if (redir_ok) begin
                        // Delay slot not fetched yet: hold the target.
                        pend_target <= redir_tgt;
                        state       <= PEND;
                    end
                end
                PEND: begin
                    // First latched target wins; new redirects ignored.
                    if (advance) begin
                        PC    <= pend_target;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed-vector bench for pc_fetch.
// Table of per-cycle stimulus/expectations plus reset-in-PEND sequence.
module tb_pc_fetch;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_addr;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        if_valid;
    logic        addr_err;

    int tests;
    int fails;

    typedef struct {
        string       name;
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] pc;
        logic        vld;
        logic        aerr;
        logic [31:0] pc_next;
    } vec_t;

    vec_t vecs[$];

    pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_ack        (imem_ack),
        .imem_addr       (imem_addr),
        .PC              (PC),
        .PC4             (PC4),
        .if_valid        (if_valid),
        .addr_err        (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic s, input logic rv,
                       input logic [31:0] t, input logic a,
                       input logic [31:0] pc, input logic vld,
                       input logic ae, input logic [31:0] pn);
        vec_t v;
        v.name = n; v.stall = s; v.rv = rv; v.tgt = t; v.ack = a;
        v.pc = pc; v.vld = vld; v.aerr = ae; v.pc_next = pn;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        stall           = v.stall;
        redirect_valid  = v.rv;
        redirect_target = v.tgt;
        imem_ack        = v.ack;
        #1;
        chk({v.name, ".pc"}, PC, v.pc);
        chk({v.name, ".addr"}, imem_addr, v.pc);
        chk({v.name, ".pc4"}, PC4, v.pc + 32'd4);
        chk({v.name, ".req"}, {31'b0, imem_req}, 32'd1);
        chk({v.name, ".vld"}, {31'b0, if_valid}, {31'b0, v.vld});
        chk({v.name, ".aerr"}, {31'b0, addr_err}, {31'b0, v.aerr});
        @(posedge clk);
        #1;
        chk({v.name, ".next"}, PC, v.pc_next);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        imem_ack = 1'b1;

        //   name     st rv tgt            ack pc             vld ae next
        add("seq0",   0, 0, 32'h0,         1, 32'h3000,      1, 0, 32'h3004);
        add("seq1",   0, 0, 32'h0,         1, 32'h3004,      1, 0, 32'h3008);
        add("rdadv",  0, 1, 32'h3100,      1, 32'h3008,      1, 0, 32'h3100);
        add("rdrun",  0, 0, 32'h0,         1, 32'h3100,      1, 0, 32'h3104);
        add("back",   0, 1, 32'h3008,      1, 32'h3104,      1, 0, 32'h3008);
        add("st0",    1, 1, 32'h3200,      1, 32'h3008,      0, 0, 32'h3008);
        add("st1",    1, 0, 32'h0,         1, 32'h3008,      0, 0, 32'h3008);
        add("st2",    1, 1, 32'h3300,      1, 32'h3008,      0, 0, 32'h3008);
        add("pend",   0, 1, 32'h3300,      1, 32'h3008,      1, 0, 32'h3200);
        add("pdone",  0, 0, 32'h0,         1, 32'h3200,      1, 0, 32'h3204);
        add("to10",   0, 1, 32'h3010,      1, 32'h3204,      1, 0, 32'h3010);
        for (int i = 0; i < 4; i++)
            add("wait", 0, 0, 32'h0,       0, 32'h3010,      0, 0, 32'h3010);
        add("wdone",  0, 0, 32'h0,         1, 32'h3010,      1, 0, 32'h3014);
        add("towrp",  0, 1, 32'hFFFF_FFFC, 1, 32'h3014,      1, 0, 32'hFFFF_FFFC);
        add("wrap",   0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 0, 32'h0);
        add("ackpd",  0, 1, 32'h40,        0, 32'h0,         0, 0, 32'h0);
        add("ackpa",  0, 1, 32'h0,         1, 32'h0,         1, 0, 32'h40);
`ifdef PC_MISALIGN_CHECK_EN
        add("mis0",   0, 1, 32'h103,       1, 32'h40,        1, 1, 32'h44);
        add("to08",   0, 1, 32'h3008,      1, 32'h44,        1, 0, 32'h3008);
        add("mis1",   0, 1, 32'h3102,      1, 32'h3008,      1, 1, 32'h300C);
        add("misst",  1, 1, 32'h3102,      1, 32'h300C,      0, 1, 32'h300C);
        add("misnp",  0, 0, 32'h0,         1, 32'h300C,      1, 0, 32'h3010);
`else
        add("mask0",  0, 1, 32'h103,       1, 32'h40,        1, 0, 32'h100);
        add("mask1",  1, 1, 32'h3102,      1, 32'h100,       0, 0, 32'h100);
        add("mask2",  0, 0, 32'h0,         1, 32'h100,       1, 0, 32'h3100);
`endif

        #2 reset_n = 1'b0;
        #1;
        chk("rst.pc", PC, 32'h3000);
        chk("rst.addr", imem_addr, 32'h3000);
        chk("rst.req", {31'b0, imem_req}, 32'd0);
        chk("rst.vld", {31'b0, if_valid}, 32'd0);
        chk("rst.aerr", {31'b0, addr_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.req", {31'b0, imem_req}, 32'd1);
        chk("rel.pc", PC, 32'h3000);

        foreach (vecs[i]) apply(vecs[i]);

        // Enter PEND, then reset: the pending target must vanish.
        @(negedge clk);
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h5000;
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        stall = 1'b0;
        #1;
        chk("rp.pc", PC, 32'h3000);
        chk("rp.req", {31'b0, imem_req}, 32'd0);
        chk("rp.vld", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rp.rel", PC, 32'h3000);
        chk("rp.vld1", {31'b0, if_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("rp.seq1", PC, 32'h3004);
        @(posedge clk);
        #1;
        chk("rp.seq2", PC, 32'h3008);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
